// File: rtl/fpu_fp64_mul_issue_if.sv
// Bundles the three links of the FP64 multiply issue stage:
// the decode handshake, the multiplier link and the result handshake.
interface fpu_fp64_mul_issue_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_srca;
  logic [63:0]      in_srcb;
  logic [TAG_W-1:0] in_tag;
  logic             mul_enable;
  logic [63:0]      mul_srca;
  logic [63:0]      mul_srcb;
  logic [63:0]      mul_dst;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_invalid;

  modport slave (
    input  in_valid, in_srca, in_srcb, in_tag, mul_dst, out_ready,
    output in_ready, mul_enable, mul_srca, mul_srcb,
           out_valid, out_data, out_tag, out_invalid
  );

  modport master (
    output in_valid, in_srca, in_srcb, in_tag, mul_dst, out_ready,
    input  in_ready, mul_enable, mul_srca, mul_srcb,
           out_valid, out_data, out_tag, out_invalid
  );
endinterface

// File: rtl/fpu_fp64_mul_issue.sv
// FP64 multiply issue stage: resolves special operands locally, otherwise
// drives the multiplier for MUL_LAT cycles and holds the result until taken.
module fpu_fp64_mul_issue #(
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fpu_fp64_mul_issue_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [3:0]       cnt_r;
  logic             in_ready_r, mul_enable_r, out_valid_r, out_invalid_r;
  logic [63:0]      mul_srca_r, mul_srcb_r, out_data_r;
  logic [TAG_W-1:0] out_tag_r;

  logic             accept_s, special_s, sign_s;
  logic             zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
  logic             snan_a_s, snan_b_s;
  logic [63:0]      spec_data_s;
  logic             spec_invalid_s;

  assign bus.in_ready    = in_ready_r;
  assign bus.mul_enable  = mul_enable_r;
  assign bus.mul_srca    = mul_srca_r;
  assign bus.mul_srcb    = mul_srcb_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_tag     = out_tag_r;
  assign bus.out_invalid = out_invalid_r;

  assign accept_s = bus.in_valid && in_ready_r;
  assign sign_s   = bus.in_srca[63] ^ bus.in_srcb[63];

  // Denormals have exponent 0 and are deliberately folded into the zero class.
  assign zero_a_s  = (bus.in_srca[62:52] == 11'h000);
  assign zero_b_s  = (bus.in_srcb[62:52] == 11'h000);
  assign inf_a_s   = (bus.in_srca[62:52] == 11'h7FF) && (bus.in_srca[51:0] == 52'd0);
  assign inf_b_s   = (bus.in_srcb[62:52] == 11'h7FF) && (bus.in_srcb[51:0] == 52'd0);
  assign nan_a_s   = (bus.in_srca[62:52] == 11'h7FF) && (bus.in_srca[51:0] != 52'd0);
  assign nan_b_s   = (bus.in_srcb[62:52] == 11'h7FF) && (bus.in_srcb[51:0] != 52'd0);
  assign snan_a_s  = nan_a_s && !bus.in_srca[51];
  assign snan_b_s  = nan_b_s && !bus.in_srcb[51];
  assign special_s = zero_a_s || zero_b_s || inf_a_s || inf_b_s || nan_a_s || nan_b_s;

  // Special-operand result, in priority order.
  always_comb begin
    spec_data_s    = 64'd0;
    spec_invalid_s = 1'b0;
    if (nan_a_s) begin
      spec_data_s    = {bus.in_srca[63:52], 1'b1, bus.in_srca[50:0]};
      spec_invalid_s = snan_a_s || snan_b_s;
    end else if (nan_b_s) begin
      spec_data_s    = {bus.in_srcb[63:52], 1'b1, bus.in_srcb[50:0]};
      spec_invalid_s = snan_b_s;
    end else if ((inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
      spec_data_s    = 64'h7FF8_0000_0000_0000;
      spec_invalid_s = 1'b1;
    end else if (inf_a_s || inf_b_s) begin
      spec_data_s    = {sign_s, 11'h7FF, 52'd0};
    end else begin
      spec_data_s    = {sign_s, 63'd0};
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = special_s ? DONE : MUL;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == 4'd0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = MUL;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, registered handshake outputs and operand/result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      in_ready_r    <= 1'b1;
      mul_enable_r  <= 1'b0;
      out_valid_r   <= 1'b0;
      out_invalid_r <= 1'b0;
      mul_srca_r    <= 64'd0;
      mul_srcb_r    <= 64'd0;
      out_data_r    <= 64'd0;
      out_tag_r     <= '0;
    end else begin
      state_r      <= next_state_s;
      in_ready_r   <= (next_state_s == IDLE);
      mul_enable_r <= (next_state_s == MUL);
      out_valid_r  <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mul_srca_r <= bus.in_srca;
            mul_srcb_r <= bus.in_srcb;
            out_tag_r  <= bus.in_tag;
            cnt_r      <= 4'(MUL_LAT - 1);
            if (special_s) begin
              out_data_r    <= spec_data_s;
              out_invalid_r <= spec_invalid_s;
            end
          end
        end
        MUL: begin
          if (cnt_r == 4'd0) begin
            out_data_r    <= bus.mul_dst;
            out_invalid_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_fp64_mul_issue.sv
// Randomized self-checking bench for fpu_fp64_mul_issue with a behavioural
// multiplier that only presents a correct product after MUL_LAT enabled cycles.
module tb_fpu_fp64_mul_issue;
  localparam int MUL_LAT = 2;
  localparam int TAG_W   = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   en_cnt;

  always #5 clk = ~clk;

  fpu_fp64_mul_issue_if #(.TAG_W(TAG_W)) bus ();

  fpu_fp64_mul_issue #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Multiplier model: garbage until the enable has been held long enough.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_cnt <= 0;
    else if (bus.mul_enable) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end
  assign bus.mul_dst = (bus.mul_enable && en_cnt >= MUL_LAT - 1)
                     ? $realtobits($bitstoreal(bus.mul_srca) * $bitstoreal(bus.mul_srcb))
                     : 64'hBAD0_BAD0_BAD0_BAD0;

  // 0 zero/denormal, 1 normal, 2 inf, 3 quiet NaN, 4 signaling NaN
  function automatic int cls(input logic [63:0] x);
    if (x[62:52] == 11'h000) return 0;
    if (x[62:52] != 11'h7FF) return 1;
    if (x[51:0] == 52'd0) return 2;
    return x[51] ? 3 : 4;
  endfunction

  function automatic void ref_mul(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] d, output logic inv, output logic spec);
    int ca = cls(a);
    int cb = cls(b);
    logic s = a[63] ^ b[63];
    spec = 1'b1;
    inv  = 1'b0;
    if (ca >= 3) begin
      d = a | (64'd1 << 51); inv = (ca == 4) || (cb == 4);
    end else if (cb >= 3) begin
      d = b | (64'd1 << 51); inv = (cb == 4);
    end else if ((ca == 2 && cb == 0) || (ca == 0 && cb == 2)) begin
      d = 64'h7FF8_0000_0000_0000; inv = 1'b1;
    end else if (ca == 2 || cb == 2) begin
      d = {s, 11'h7FF, 52'd0};
    end else if (ca == 0 || cb == 0) begin
      d = {s, 63'd0};
    end else begin
      spec = 1'b0;
      d = $realtobits($bitstoreal(a) * $bitstoreal(b));
    end
  endfunction

  function automatic logic [63:0] rand_operand(input int kind);
    logic [63:0] r;
    logic        s;
    r = {$urandom, $urandom};
    s = r[63];
    case (kind)
      0: return {s, 11'h000, ($urandom_range(0, 1) == 0) ? 52'd0 : r[51:0]};
      1: return {s, 11'h7FF, 52'd0};
      2: return {s, 11'h7FF, 1'b1, r[50:0]};
      3: return {s, 11'h7FF, 1'b0, r[50:1], 1'b1};
      default: return {s, 11'($urandom_range(768, 1279)), r[51:0]};
    endcase
  endfunction

  // Issue one operation and retire it; reports latency and enable cycles.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t,
                       output int lat, output int en, output logic [63:0] d,
                       output logic [TAG_W-1:0] ot, output logic inv, output logic ok);
    int n = 0;
    lat = 0; en = 0; d = 64'd0; ot = '0; inv = 1'b0; ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_srca = a; bus.in_srcb = b; bus.in_tag = t;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.mul_enable) en++;
      @(negedge clk); lat++;
    end
    ok = bus.out_valid; d = bus.out_data; ot = bus.out_tag; inv = bus.out_invalid;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_srca = 64'd0; bus.in_srcb = 64'd0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.mul_enable, bus.out_invalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 1000", {bus.in_ready, bus.out_valid, bus.mul_enable, bus.out_invalid});
    end
    n_cmp++;
    if ({bus.mul_srca, bus.mul_srcb, bus.out_data, bus.out_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h want 0", bus.mul_srca, bus.mul_srcb, bus.out_data, bus.out_tag);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    int lat, en; logic [63:0] d; logic [TAG_W-1:0] ot; logic inv, ok;
    do_op(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'd3, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL normal_timeout got %b want 1", ok); end
    n_cmp++; if (lat !== MUL_LAT + 1) begin n_fail++; $display("FAIL normal_latency got %0d want %0d", lat, MUL_LAT + 1); end
    n_cmp++; if (en !== MUL_LAT) begin n_fail++; $display("FAIL normal_enable got %0d want %0d", en, MUL_LAT); end
    n_cmp++; if (d !== 64'h4018_0000_0000_0000) begin n_fail++; $display("FAIL normal_data got %h want 4018000000000000", d); end
    n_cmp++; if ({ot, inv} !== {5'd3, 1'b0}) begin n_fail++; $display("FAIL normal_tag_inv got %0d/%b want 3/0", ot, inv); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL normal_retire got ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_inf_zero();
    int lat, en; logic [63:0] d; logic [TAG_W-1:0] ot; logic inv, ok;
    do_op(64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 5'd11, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL infzero_latency got %0d ok=%b want 1", lat, ok); end
    n_cmp++; if (en !== 0) begin n_fail++; $display("FAIL infzero_enable got %0d want 0", en); end
    n_cmp++; if (d !== 64'h7FF8_0000_0000_0000 || inv !== 1'b1 || ot !== 5'd11) begin
      n_fail++; $display("FAIL infzero_result got %h inv=%b tag=%0d want 7ff8000000000000 1 11", d, inv, ot);
    end
  endtask

  task automatic test_signed_zero();
    int lat, en; logic [63:0] d; logic [TAG_W-1:0] ot; logic inv, ok;
    do_op(64'h8000_0000_0000_0000, 64'h4014_0000_0000_0000, 5'd1, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1 || d !== 64'h8000_0000_0000_0000 || inv !== 1'b0) begin
      n_fail++; $display("FAIL negzero got %h inv=%b want 8000000000000000 0", d, inv);
    end
    do_op(64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 5'd2, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1 || d !== 64'h0 || inv !== 1'b0 || lat !== 1) begin
      n_fail++; $display("FAIL denorm_flush got %h inv=%b lat=%0d want 0 0 1", d, inv, lat);
    end
  endtask

  task automatic test_nan();
    int lat, en; logic [63:0] d; logic [TAG_W-1:0] ot; logic inv, ok;
    do_op(64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0002, 5'd5, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1 || d !== 64'h7FF8_0000_0000_0001 || inv !== 1'b1) begin
      n_fail++; $display("FAIL nan_prop got %h inv=%b want 7ff8000000000001 1", d, inv);
    end
    do_op(64'h3FF0_0000_0000_0000, 64'hFFF8_0000_0000_00AB, 5'd6, lat, en, d, ot, inv, ok);
    n_cmp++; if (ok !== 1'b1 || d !== 64'hFFF8_0000_0000_00AB || inv !== 1'b0) begin
      n_fail++; $display("FAIL qnan_b got %h inv=%b want fff80000000000ab 0", d, inv);
    end
  endtask

  task automatic test_back_to_back();
    logic stable = 1'b1;
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_srca = 64'hFFF0_0000_0000_0000; bus.in_srcb = 64'h4000_0000_0000_0000; bus.in_tag = 5'd7;
    @(negedge clk);
    bus.in_srca = 64'h4000_0000_0000_0000; bus.in_srcb = 64'h3FF8_0000_0000_0000; bus.in_tag = 5'd9;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hFFF0_0000_0000_0000 ||
          bus.out_tag !== 5'd7 || bus.in_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold got unstable data=%h tag=%0d want fff0000000000000 7", bus.out_data, bus.out_tag); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mul_enable !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got ov=%b ir=%b en=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.mul_enable);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.mul_enable !== 1'b1) begin
      n_fail++; $display("FAIL bp_second_accept got ir=%b en=%b want 0 1", bus.in_ready, bus.mul_enable);
    end
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h4008_0000_0000_0000 || bus.out_tag !== 5'd9) begin
      n_fail++; $display("FAIL bp_second_result got %h tag=%0d want 4008000000000000 9", bus.out_data, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    logic stale = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_srca = 64'h4000_0000_0000_0000; bus.in_srcb = 64'h4000_0000_0000_0000; bus.in_tag = 5'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.mul_enable !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_abort got ov=%b en=%b ir=%b want 0 0 1", bus.out_valid, bus.mul_enable, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.mul_enable !== 1'b0) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_stale got stale=%b ir=%b want 0 1", stale, bus.in_ready);
    end
  endtask

  task automatic test_random();
    int lat, en, bad = 0;
    logic [63:0] a, b, d, ed;
    logic [TAG_W-1:0] t, ot;
    logic inv, ok, einv, espec;
    for (int i = 0; i < 40; i++) begin
      a = rand_operand($urandom_range(0, 5));
      b = rand_operand($urandom_range(0, 5));
      t = TAG_W'($urandom);
      ref_mul(a, b, ed, einv, espec);
      do_op(a, b, t, lat, en, d, ot, inv, ok);
      n_cmp++;
      if (ok !== 1'b1 || d !== ed || inv !== einv || ot !== t ||
          lat !== (espec ? 1 : MUL_LAT + 1) || en !== (espec ? 0 : MUL_LAT)) begin
        n_fail++; bad++;
        if (bad < 6)
          $display("FAIL random_%0d a=%h b=%h got %h inv=%b tag=%0d lat=%0d en=%0d want %h inv=%b tag=%0d spec=%b",
                   i, a, b, d, inv, ot, lat, en, ed, einv, t, espec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_inf_zero();
    test_signed_zero();
    test_nan();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
